// File: rtl/counter_down_reload_pkg.sv
// counter_down_reload_pkg: shared definitions for the loadable down-counter.
//   state_e  - run-control states (IDLE/RUN/DONE), 2-bit encoding
//   ST_WIDTH - width of the state encoding
package counter_down_reload_pkg;

  localparam int unsigned ST_WIDTH = 2;

  typedef enum logic [ST_WIDTH-1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/counter_down_reload_if.sv
// counter_down_reload_if: control/status bundle of the down-counter.
//   CLR       - synchronous clear (active level set by the counter's CLEAR_VAL)
//   DCLR      - value loaded on clear
//   LOAD      - load/start strobe, active-high
//   DLOAD     - start value, also the reload value
//   EN        - count enable
//   Q, notQ   - registered count and its bitwise inverse
//   underflow - one-cycle pulse on a decrement attempted at zero
//   busy/done - run-control status
// Modports: master drives the controls, slave is the counter itself.
interface counter_down_reload_if #(
  parameter int unsigned DATA_WIDTH = 4
);

  logic                  CLR;
  logic [DATA_WIDTH-1:0] DCLR;
  logic                  LOAD;
  logic [DATA_WIDTH-1:0] DLOAD;
  logic                  EN;
  logic [DATA_WIDTH-1:0] Q;
  logic [DATA_WIDTH-1:0] notQ;
  logic                  underflow;
  logic                  busy;
  logic                  done;

  modport master (
    output CLR, DCLR, LOAD, DLOAD, EN,
    input  Q, notQ, underflow, busy, done
  );

  modport slave (
    input  CLR, DCLR, LOAD, DLOAD, EN,
    output Q, notQ, underflow, busy, done
  );

endinterface

// File: rtl/counter_down_reload.sv
// counter_down_reload: loadable down-counter with underflow pulse and run control.
//   C    - clock, rising edge
//   notR - asynchronous active-low reset
//   bus  - counter_down_reload_if.slave (clear/load/enable in, count/status out)
// Priority at each edge: clear > load > count. A decrement attempted at zero
// pulses underflow for one cycle and either stops in DONE (one-shot) or, with
// COUNTER_DOWN_RELOAD_AUTO_RELOAD_EN defined, reloads the last loaded value and
// keeps running. All outputs come from registers only.
module counter_down_reload
  import counter_down_reload_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter bit          CLEAR_VAL  = 1'b1
) (
  input logic                C,
  input logic                notR,
  counter_down_reload_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] One = DATA_WIDTH'(1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] q_q;
  logic                  underflow_q;
  logic                  clr_act;

`ifdef COUNTER_DOWN_RELOAD_AUTO_RELOAD_EN
  logic [DATA_WIDTH-1:0] reload_q;
`endif

  assign clr_act = (bus.CLR == CLEAR_VAL);

  always_ff @(posedge C or negedge notR) begin
    if (!notR) begin
      state_q     <= StIdle;
      q_q         <= '0;
      underflow_q <= 1'b0;
`ifdef COUNTER_DOWN_RELOAD_AUTO_RELOAD_EN
      reload_q    <= '0;
`endif
    end else if (clr_act) begin
      // Clear leaves the reload value alone.
      state_q     <= StIdle;
      q_q         <= bus.DCLR;
      underflow_q <= 1'b0;
    end else if (bus.LOAD) begin
      state_q     <= StRun;
      q_q         <= bus.DLOAD;
      underflow_q <= 1'b0;
`ifdef COUNTER_DOWN_RELOAD_AUTO_RELOAD_EN
      reload_q    <= bus.DLOAD;
`endif
    end else begin
      underflow_q <= 1'b0;
      if (state_q == StRun && bus.EN) begin
        if (q_q != '0) begin
          q_q <= q_q - One;
        end else begin
          underflow_q <= 1'b1;
`ifdef COUNTER_DOWN_RELOAD_AUTO_RELOAD_EN
          q_q         <= reload_q;
`else
          // One-shot build keeps no reload copy: nothing would ever read it.
          state_q     <= StDone;
`endif
        end
      end
    end
  end

  assign bus.Q         = q_q;
  assign bus.notQ      = ~q_q;
  assign bus.underflow = underflow_q;
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_counter_down_reload.sv
// tb_counter_down_reload: directed and randomized bench for counter_down_reload
// (DATA_WIDTH=4, CLEAR_VAL=1). The reference model tracks the count as an
// integer and a running/finished flag pair, following the counter's rules.
module tb_counter_down_reload;

  logic clk;
  logic rst_n;

  counter_down_reload_if #(.DATA_WIDTH(4)) bus ();

  counter_down_reload #(
    .DATA_WIDTH(4),
    .CLEAR_VAL (1'b1)
  ) dut (
    .C   (clk),
    .notR(rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model
  int m_count;
  int m_reload;
  bit m_running;
  bit m_finished;
  bit m_tick;

  function automatic void model_reset();
    m_count    = 0;
    m_reload   = 0;
    m_running  = 0;
    m_finished = 0;
    m_tick     = 0;
  endfunction

  function automatic void model_edge();
    if (rst_n === 1'b0) begin
      model_reset();
      return;
    end
    m_tick = 0;
    if (bus.CLR) begin
      m_count    = int'(bus.DCLR);
      m_running  = 0;
      m_finished = 0;
    end else if (bus.LOAD) begin
      m_count    = int'(bus.DLOAD);
      m_reload   = int'(bus.DLOAD);
      m_running  = 1;
      m_finished = 0;
    end else if (m_running && bus.EN) begin
      if (m_count > 0) begin
        m_count = m_count - 1;
      end else begin
        m_tick = 1;
`ifdef COUNTER_DOWN_RELOAD_AUTO_RELOAD_EN
        m_count = m_reload;
`else
        m_running  = 0;
        m_finished = 1;
`endif
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [3:0] exp_q;
    exp_q = 4'(m_count);
    checks++;
    assert (bus.Q === exp_q) else begin
      failures++;
      $error("FAIL %s Q got %0h exp %0h", tag, bus.Q, exp_q);
    end
    checks++;
    assert (bus.notQ === ~exp_q) else begin
      failures++;
      $error("FAIL %s notQ got %0h exp %0h", tag, bus.notQ, ~exp_q);
    end
    checks++;
    assert (bus.underflow === m_tick) else begin
      failures++;
      $error("FAIL %s underflow got %0b exp %0b", tag, bus.underflow, m_tick);
    end
    checks++;
    assert (bus.busy === m_running) else begin
      failures++;
      $error("FAIL %s busy got %0b exp %0b", tag, bus.busy, m_running);
    end
    checks++;
    assert (bus.done === m_finished) else begin
      failures++;
      $error("FAIL %s done got %0b exp %0b", tag, bus.done, m_finished);
    end
  endtask

  // One clock edge: model follows the inputs present at the edge, outputs
  // are sampled 1 time unit later, and inputs then change away from the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit clr, input logic [3:0] dclr, input bit load,
                        input logic [3:0] dload, input bit en);
    bus.CLR   = clr;
    bus.DCLR  = dclr;
    bus.LOAD  = load;
    bus.DLOAD = dload;
    bus.EN    = en;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 4'h0, 0, 4'h0, 0);
    model_reset();

    // 1. Reset state, then release
    #3;
    check_all("reset");
    tick("reset_held");
    rst_n = 1'b1;
    tick("reset_released");

    // Mid-run asynchronous reset
    set_in(0, 4'h0, 1, 4'h9, 1);
    tick("load9");
    set_in(0, 4'h0, 0, 4'h0, 1);
    tick("run9_a");
    tick("run9_b");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset_mid_run");
    tick("async_reset_held");
    rst_n = 1'b1;
    tick("after_async_reset");

    // 2/3. Load 3 with continuous enable: one-shot stops, auto-reload repeats
    set_in(0, 4'h0, 1, 4'h3, 1);
    tick("load3");
    set_in(0, 4'h0, 0, 4'h0, 1);
    for (int i = 0; i < 10; i++) tick("count3");

    // 4. Load 5, hold with EN=0 for 3 cycles, then decrement
    set_in(0, 4'h0, 1, 4'h5, 0);
    tick("load5");
    set_in(0, 4'h0, 0, 4'h0, 0);
    for (int i = 0; i < 3; i++) tick("hold5");
    set_in(0, 4'h0, 0, 4'h0, 1);
    tick("dec_to4");

    // 5. Clear wins over load on the same edge, then load alone
    set_in(1, 4'h9, 1, 4'h7, 1);
    tick("clr_over_load");
    set_in(0, 4'h0, 0, 4'h0, 1);
    tick("idle_ignores_en");
    set_in(0, 4'h0, 1, 4'h7, 0);
    tick("load7");

    // 6. DLOAD=0 underflows on the first enabled edge; reload from DONE
    set_in(0, 4'h0, 1, 4'h0, 1);
    tick("load0");
    set_in(0, 4'h0, 0, 4'h0, 1);
    for (int i = 0; i < 3; i++) tick("zero_period");
    set_in(0, 4'h0, 1, 4'h2, 1);
    tick("reload_from_done");
    set_in(0, 4'h0, 0, 4'h0, 1);
    for (int i = 0; i < 4; i++) tick("count2");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 6)),
             ($urandom_range(0, 3) != 0));
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled simulation.
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

endmodule
